// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and control codes for the multi-cycle RV32I controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7b5 to ALUControl decode for the execute states
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       isRType,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (funct3)
      3'b000:  aluControl = (isRType && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  aluControl = ALU_SLT;
      3'b100:  aluControl = ALU_XOR;
      3'b110:  aluControl = ALU_OR;
      3'b111:  aluControl = ALU_AND;
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I main control FSM; MEM_READY_EN adds MemReady stalls
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
`ifdef MEM_READY_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc
);

  state_t     state, nextState;
  logic       memReady;
  logic       branchTaken;
  logic [2:0] aluDecoded;

`ifdef MEM_READY_EN
  assign memReady = MemReady;
`else
  assign memReady = 1'b1;
`endif

  assign ImmSrc = immSrcFor(op);

  alu_decoder uAluDecoder (
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .isRType   (state == S_EXECR),
    .aluControl(aluDecoded)
  );

  always_comb begin
    case (funct3)
      3'b000:  branchTaken = Zero;
      3'b001:  branchTaken = !Zero;
      3'b100:  branchTaken = Neg;
      3'b101:  branchTaken = !Neg;
      default: branchTaken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= nextState;
  end

  always_comb begin
    nextState  = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        IRWrite   = memReady;
        PCWrite   = memReady;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        nextState = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: nextState = S_MEMADR;
          OP_RTYPE:          nextState = S_EXECR;
          OP_ITYPE:          nextState = S_EXECI;
          OP_BRANCH:         nextState = S_BRANCH;
          OP_JAL:            nextState = S_JAL;
          OP_JALR:           nextState = S_JALR;
          OP_LUI:            nextState = S_LUI;
          default:           nextState = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        nextState = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        nextState = memReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        nextState = memReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = aluDecoded;
        nextState  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = aluDecoded;
        nextState  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_SUB;
        PCWrite    = branchTaken;
      end
      S_JAL: begin
        // PC takes the DECODE target from ALUOut while the ALU forms the link.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        PCWrite   = 1'b1;
        nextState = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        nextState = S_JALRPC;
      end
      S_JALRPC: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        PCWrite   = 1'b1;
        nextState = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc = RES_IMM;
        RegWrite  = 1'b1;
      end
      default: nextState = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - vector-table bench for multicycle_controller (MEM_READY_EN aware)
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  typedef struct {
    string       name;
    logic        rst;
    logic        mr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        n;
    logic [16:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0;
  logic Zero = 1'b0;
  logic Neg = 1'b0;
`ifdef MEM_READY_EN
  logic MemReady = 1'b1;
`endif
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  vec_t vecs[$];
  logic [16:0] scoreboard[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg),
`ifdef MEM_READY_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc)
  );

  function automatic logic [16:0] mk(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] alu, imm);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm};
  endfunction

  function automatic logic [16:0] fetchV(input logic [2:0] imm);
    return mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, imm);
  endfunction

  function automatic logic [16:0] decodeV(input logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, imm);
  endfunction

  function automatic logic [16:0] aluwbV(input logic [2:0] imm);
    return mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, imm);
  endfunction

  task automatic addv(input string nm, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, z, n, input logic [16:0] e);
    vec_t v;
    v.name = nm; v.rst = 1'b1; v.mr = 1'b1; v.op = o; v.f3 = f3; v.f7 = f7;
    v.z = z; v.n = n; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic addx(input string nm, input logic rst, mr, input logic [6:0] o,
                      input logic [16:0] e);
    vec_t v;
    v.name = nm; v.rst = rst; v.mr = mr; v.op = o; v.f3 = '0; v.f7 = 1'b0;
    v.z = 1'b0; v.n = 1'b0; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic addFD(input string nm, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, z, n, input logic [2:0] imm);
    addv({nm, ".fetch"}, o, f3, f7, z, n, fetchV(imm));
    addv({nm, ".decode"}, o, f3, f7, z, n, decodeV(imm));
  endtask

  task automatic step(input vec_t v);
    logic [16:0] want, got;
    @(negedge clk);
    rst_n = v.rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; Neg = v.n;
`ifdef MEM_READY_EN
    MemReady = v.mr;
`endif
    scoreboard.push_back(v.exp);
    #1;
    want = scoreboard.pop_front();
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%05h want=%05h", v.name, got, want);
    end
  endtask

  initial begin
    addx("reset.0", 0, 1, 7'd0, fetchV(3'd0));
    addx("reset.1", 0, 1, 7'd0, fetchV(3'd0));

    addFD("lw", OP_LW, 3'b010, 0, 0, 0, 3'd0);
    addv("lw.memadr", OP_LW, 3'b010, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    addv("lw.memread", OP_LW, 3'b010, 0, 0, 0, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    addv("lw.memwb", OP_LW, 3'b010, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0));

    addFD("sw", OP_SW, 3'b010, 0, 0, 0, 3'd1);
    addv("sw.memadr", OP_SW, 3'b010, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1));
    addv("sw.memwrite", OP_SW, 3'b010, 0, 0, 0, mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1));

    addFD("sub", OP_R, 3'b000, 1, 0, 0, 3'd0);
    addv("sub.execr", OP_R, 3'b000, 1, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd0));
    addv("sub.aluwb", OP_R, 3'b000, 1, 0, 0, aluwbV(3'd0));

    addFD("addi", OP_I, 3'b000, 1, 0, 0, 3'd0);
    addv("addi.execi", OP_I, 3'b000, 1, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    addv("addi.aluwb", OP_I, 3'b000, 1, 0, 0, aluwbV(3'd0));

    addFD("xor", OP_R, 3'b100, 0, 0, 0, 3'd0);
    addv("xor.execr", OP_R, 3'b100, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd4, 3'd0));
    addv("xor.aluwb", OP_R, 3'b100, 0, 0, 0, aluwbV(3'd0));

    addFD("ori", OP_I, 3'b110, 0, 0, 0, 3'd0);
    addv("ori.execi", OP_I, 3'b110, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd3, 3'd0));
    addv("ori.aluwb", OP_I, 3'b110, 0, 0, 0, aluwbV(3'd0));

    addFD("slti", OP_I, 3'b010, 0, 0, 0, 3'd0);
    addv("slti.execi", OP_I, 3'b010, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd5, 3'd0));
    addv("slti.aluwb", OP_I, 3'b010, 0, 0, 0, aluwbV(3'd0));

    addFD("and", OP_R, 3'b111, 1, 0, 0, 3'd0);
    addv("and.execr", OP_R, 3'b111, 1, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd2, 3'd0));
    addv("and.aluwb", OP_R, 3'b111, 1, 0, 0, aluwbV(3'd0));

    addFD("bneTaken", OP_BR, 3'b001, 0, 0, 0, 3'd2);
    addv("bneTaken.branch", OP_BR, 3'b001, 0, 0, 0, mk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd2));
    addFD("bneNot", OP_BR, 3'b001, 0, 1, 0, 3'd2);
    addv("bneNot.branch", OP_BR, 3'b001, 0, 1, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd2));
    addFD("beq", OP_BR, 3'b000, 0, 1, 0, 3'd2);
    addv("beq.branch", OP_BR, 3'b000, 0, 1, 0, mk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd2));
    addFD("blt", OP_BR, 3'b100, 0, 0, 1, 3'd2);
    addv("blt.branch", OP_BR, 3'b100, 0, 0, 1, mk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd2));
    addFD("bge", OP_BR, 3'b101, 0, 0, 1, 3'd2);
    addv("bge.branch", OP_BR, 3'b101, 0, 0, 1, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd2));
    addFD("b010", OP_BR, 3'b010, 0, 1, 1, 3'd2);
    addv("b010.branch", OP_BR, 3'b010, 0, 1, 1, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd2));

    addFD("jal", OP_JAL, 3'b000, 0, 0, 0, 3'd3);
    addv("jal.jal", OP_JAL, 3'b000, 0, 0, 0, mk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd3));
    addv("jal.aluwb", OP_JAL, 3'b000, 0, 0, 0, aluwbV(3'd3));

    addFD("lui", OP_LUI, 3'b000, 0, 0, 0, 3'd7);
    addv("lui.lui", OP_LUI, 3'b000, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0, 3'd0, 3'd7));

    addFD("illegal", OP_BAD, 3'b000, 0, 0, 0, 3'd0);

    addFD("jalr", OP_JALR, 3'b000, 0, 0, 0, 3'd0);
    addv("jalr.jalr", OP_JALR, 3'b000, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    addv("jalr.jalrpc", OP_JALR, 3'b000, 0, 0, 0, mk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0));
    addv("jalr.aluwb", OP_JALR, 3'b000, 0, 0, 0, aluwbV(3'd0));
    addv("after.fetch", OP_LUI, 3'b000, 0, 0, 0, fetchV(3'd7));
    addv("after.decode", OP_LUI, 3'b000, 0, 0, 0, decodeV(3'd7));
    addv("after.lui", OP_LUI, 3'b000, 0, 0, 0, mk(0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0, 3'd0, 3'd7));

    // Hand-written multi-cycle corners: reset abandoning an instruction mid-flight.
    addFD("rstSw", OP_SW, 3'b010, 0, 0, 0, 3'd1);
    addx("rstSw.memadr", 0, 1, OP_SW, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1));
    addx("rstSw.fetch", 1, 1, OP_SW, fetchV(3'd1));
    addx("rstSw.decode", 1, 1, OP_SW, decodeV(3'd1));
    addx("rstSw.memadr2", 1, 1, OP_SW, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1));
    addx("rstSw.memwrite", 1, 1, OP_SW, mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1));
    addFD("rstLw", OP_LW, 3'b010, 0, 0, 0, 3'd0);
    addx("rstLw.memadr", 1, 1, OP_LW, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    addx("rstLw.memread", 0, 1, OP_LW, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    addx("rstLw.fetch", 1, 1, OP_LW, fetchV(3'd0));
    addx("rstLw.decode", 1, 1, OP_LW, decodeV(3'd0));
    addx("rstLw.memadr2", 1, 1, OP_LW, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    addx("rstLw.memread2", 1, 1, OP_LW, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    addx("rstLw.memwb", 1, 1, OP_LW, mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0));

`ifdef MEM_READY_EN
    for (int i = 0; i < 3; i++)
      addx("holdFetch.stall", 1, 0, OP_BAD, mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    addx("holdFetch.go", 1, 1, OP_BAD, fetchV(3'd0));
    addx("holdFetch.decode", 1, 1, OP_BAD, decodeV(3'd0));
    addFD("holdLw", OP_LW, 3'b010, 0, 0, 0, 3'd0);
    addx("holdLw.memadr", 1, 1, OP_LW, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
    addx("holdLw.memread0", 1, 0, OP_LW, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    addx("holdLw.memread1", 1, 0, OP_LW, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    addx("holdLw.memread2", 1, 1, OP_LW, mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
    addx("holdLw.memwb", 1, 1, OP_LW, mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0));
    addFD("holdSw", OP_SW, 3'b010, 0, 0, 0, 3'd1);
    addx("holdSw.memadr", 1, 1, OP_SW, mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1));
    addx("holdSw.memwrite0", 1, 0, OP_SW, mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1));
    addx("holdSw.memwriteRst", 0, 0, OP_SW, mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1));
    addx("holdSw.fetch", 1, 1, OP_SW, fetchV(3'd1));
    addx("holdSw.decode", 1, 1, OP_SW, decodeV(3'd1));
`endif

    foreach (vecs[i]) step(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM of the multi-cycle RV32I core. It decodes the opcode held in the instruction register and sequences the per-cycle datapath strobes: PC/IR/register-file/memory write enables, mux selects and ALU operation. It sits directly upstream of the immediate extender, which it drives with `ImmSrc`; it sits beside the ALU, whose flags close the branch decision.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `op`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `funct7b5`  in  1  IR[30]
- `Zero`  in  1  ALU result == 0
- `Neg`  in  1  ALU result sign bit
- `MemReady`  in  1  memory access complete; only present with `MEM_READY_EN`
- `PCWrite`  out  1  load PC
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  data memory store strobe
- `IRWrite`  out  1  load IR and OldPC
- `RegWrite`  out  1  register-file write
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU direct, 11 = ImmExt
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- `ImmSrc`  out  3  000 I, 001 S, 010 B, 011 J, 111 U

## Operation
**ImmSrc** is combinational from `op` in every state:
- lw, I-ALU, jalr → 000
- sw → 001
- branch → 010
- jal → 011
- lui → 111
- any other opcode → 000

**Unlisted outputs** are 0 in every state. `ALUControl` defaults to add.

**States and transitions:**
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 lw or 0100011 sw → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - any other opcode → FETCH, no side effects.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl from funct → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=1 when taken → FETCH.
  - funct3 000 beq: taken on Zero.
  - funct3 001 bne: taken on !Zero.
  - funct3 100 blt: taken on Neg.
  - funct3 101 bge: taken on !Neg.
  - any other funct3: never taken.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 (target from DECODE), PCWrite=1 → ALUWB (link = OldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, add → JALRPC.
- JALRPC: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add → ALUWB.
- LUI: ResultSrc=11, RegWrite=1 → FETCH.

**ALU function decode** (funct3 → ALUControl):
- 000: add. Sub only when EXECR and funct7b5=1.
- 010: slt.
- 100: xor.
- 110: or.
- 111: and.
- Others: add.

## Timing
- Moore outputs, except BRANCH PCWrite, which is combinational on `Zero`/`Neg` in the same cycle.
- Cycles per instruction:
  - lw: 5
  - sw: 4
  - R/I-type: 4
  - branch: 3
  - jal: 4
  - jalr: 5
  - lui: 3
  - illegal opcode: 2
- Reset: `rst_n` low at a rising edge → state FETCH on the next cycle, overriding any transition. Mid-instruction reset abandons the instruction; no write strobe is issued after the reset edge.
- While `rst_n` is low, outputs show FETCH values registered from the previous state only until the edge; afterwards they are FETCH values.

## Configuration
`MEM_READY_EN`:
- **Defined:** `MemReady` port exists.
  - FETCH holds while MemReady=0, with IRWrite=0 and PCWrite=0. On MemReady=1 it asserts both and advances.
  - MEMREAD and MEMWRITE hold while MemReady=0. MemWrite stays asserted through the hold.
  - Reset overrides any hold.
- **Undefined:** port absent; every state lasts exactly one cycle.

## Structure
- Package `ctrl_pkg` holds:
  - state enum
  - opcode constants
  - `ALUControl`, `ImmSrc`, `ResultSrc` and `ALUSrc` code constants
- One sub-module, `alu_decoder`: combinational `funct3`/`funct7b5`/mode → `ALUControl`.

## Test plan
- Reset then `lw` (op=0000011): FETCH→DECODE→MEMADR→MEMREAD→MEMWB. ImmSrc=000. RegWrite=1 only in cycle 5, with ResultSrc=01.
- `sw` (op=0100011): ImmSrc=001. MemWrite=1 with AdrSrc=1 exactly in cycle 4, then FETCH.
- `sub` (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECR. `addi` with funct7b5=1 gives ALUControl=000.
- `bne` (funct3=001):
  - Zero=0 → PCWrite=1 in cycle 3.
  - Zero=1 → PCWrite=0.
  - Either way FETCH follows; ImmSrc=010.
- `jal` then `lui`:
  - jal: PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=011.
  - lui: ResultSrc=11, RegWrite=1 in cycle 3, ImmSrc=111.
  - op=1111111: DECODE→FETCH with no strobes.
- `MEM_READY_EN` build, MemReady held 0 for 3 cycles in FETCH: IRWrite=0 for those 3 cycles, then 1 for one cycle. `rst_n`=0 asserted during a MEMWRITE hold → next state FETCH and MemWrite=0.
